buff_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-driver buffer path (input bit(s) passed straight to output) among N requesters.
- Grants exactly one requester at a time and steers that requester's data onto the shared output `x`.
- Enforces a maximum hold time so that a continuously requesting source cannot starve the others.
- Sits between the requester sources and the shared buffer/output line.

---
 rtl/buff_arbiter.sv | 127 ++++++++++++
 tb/tb_buff_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/buff_arbiter.sv
// Round-robin arbiter steering one of N requesters' data onto a shared buffer output x.
// Grant is registered (visible one edge after req); x follows the granted din combinationally; a holder is forced off after MAX_HOLD cycles only while others wait.
module buff_arbiter #(
   parameter int N        = 4,
   parameter int DATA_W   = 1,
   parameter int MAX_HOLD = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N-1:0]        req,
   input  logic [N*DATA_W-1:0] din,
   output logic [N-1:0]        gnt,
   output logic [DATA_W-1:0]   x,
   output logic                x_valid,
   output logic                busy
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [N-1:0]    gnt_q, gnt_d;

   logic [PW-1:0]   g_idx;
   logic [PW-1:0]   ptr_rel;
   logic [N-1:0]    others;
   logic [N-1:0]    pick;
   logic            release_g;

   // First set bit of r scanning p, p+1, ... modulo N.
   function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
      logic [N-1:0] o;
      logic         found;
      int           idx;
      o     = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(p) + k) % N;
         if (!found && r[idx]) begin
            o[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return o;
   endfunction

   function automatic logic [PW-1:0] oh_index(input logic [N-1:0] oh);
      logic [PW-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (oh[i]) idx = PW'(i);
      end
      return idx;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         gnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_q      <= gnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      gnt_d      = gnt_q;
      pick       = '0;
      g_idx      = oh_index(gnt_q);
      others     = req & ~gnt_q;
      ptr_rel    = PW'((int'(g_idx) + 1) % N);
      // An expired hold only yields when someone else is actually waiting.
      release_g  = (~|(req & gnt_q)) || ((hold_cnt_q == HOLD_MAX) && (|others));
      case (state_q)
         IDLE: begin
            pick = rr_pick(req, ptr_q);
            gnt_d = pick;
            if (|pick) begin
               state_d    = GRANT;
               hold_cnt_d = HOLD_ONE;
            end
         end
         GRANT: begin
            if (release_g) begin
               ptr_d = ptr_rel;
               pick  = rr_pick(others, ptr_rel);
               gnt_d = pick;
               if (|pick) begin
                  hold_cnt_d = HOLD_ONE;
               end else begin
                  state_d    = IDLE;
                  hold_cnt_d = '0;
               end
            end else if (hold_cnt_q != HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      x = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_q[i]) x = x | din[i*DATA_W +: DATA_W];
      end
      gnt     = gnt_q;
      x_valid = |gnt_q;
      busy    = (state_q == GRANT);
   end

endmodule

// File: tb/tb_buff_arbiter.sv
// Bench for buff_arbiter: directed vector table, hand-written corner sequences, and random traffic against a reference model.
module tb_buff_arbiter;
   localparam int N  = 4;
   localparam int DW = 1;
   localparam int MH = 8;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*DW-1:0] din;
   logic [N-1:0]    gnt;
   logic [DW-1:0]   x;
   logic            x_valid;
   logic            busy;

   int total = 0;
   int bad   = 0;

   // Reference model: current owner (-1 when idle), rotating pointer, hold count.
   int m_own;
   int m_ptr;
   int m_hold;

   typedef struct {
      logic [3:0] req;
      logic [3:0] din;
      logic [3:0] gnt;
      logic       x;
      logic       vld;
      logic       busy;
   } vec_t;

   vec_t vt[9];

   buff_arbiter #(.N(N), .DATA_W(DW), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .din(din),
      .gnt(gnt), .x(x), .x_valid(x_valid), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int scan(input logic [N-1:0] r, input int p, input int excl);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (p + k) % N;
         if (r[idx] && idx != excl) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_own  = -1;
      m_ptr  = 0;
      m_hold = 0;
   endtask

   task automatic model_update(input logic [N-1:0] r);
      logic others;
      if (m_own < 0) begin
         m_own = scan(r, m_ptr, -1);
         if (m_own >= 0) m_hold = 1;
      end else begin
         others = 1'b0;
         for (int j = 0; j < N; j++) if (j != m_own && r[j]) others = 1'b1;
         if (!r[m_own] || (m_hold == MH && others)) begin
            m_ptr  = (m_own + 1) % N;
            m_own  = scan(r, m_ptr, m_own);
            m_hold = (m_own >= 0) ? 1 : 0;
         end else if (m_hold < MH) begin
            m_hold = m_hold + 1;
         end
      end
   endtask

   // One clock: model advances on the rising edge, outputs are observed at the falling edge.
   task automatic step();
      @(posedge clk);
      if (rst_n) model_update(req);
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      logic [3:0] eg;
      logic       ex;
      eg = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
      ex = (m_own >= 0) ? din[m_own] : 1'b0;
      chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
      chk({tag, "_x"}, 32'(x), 32'(ex));
      chk({tag, "_vld"}, 32'(x_valid), 32'(m_own >= 0));
      chk({tag, "_busy"}, 32'(busy), 32'(m_own >= 0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         req = 4'($urandom_range(0, 15));
         din = 4'($urandom_range(0, 15));
         #1;
         chk("rst_gnt", 32'(gnt), 32'h0);
         chk("rst_x", 32'(x), 32'h0);
         chk("rst_vld", 32'(x_valid), 32'h0);
         chk("rst_busy", 32'(busy), 32'h0);
         @(negedge clk);
      end
      req   = '0;
      din   = '0;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      din   = '0;
      model_reset();

      // req, din, expected gnt, x, x_valid, busy -- starting from reset (ptr=0)
      vt[0] = '{4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1}; // single request
      vt[1] = '{4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0}; // release idx1 -> ptr=2
      vt[2] = '{4'b1001, 4'b1001, 4'b1000, 1'b1, 1'b1, 1'b1}; // rotation picks 3 before 0
      vt[3] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1}; // release 3 -> 0 directly
      vt[4] = '{4'b0101, 4'b0100, 4'b0001, 1'b0, 1'b1, 1'b1}; // hold owner 0
      vt[5] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1}; // handoff 0 -> 2, no bubble
      vt[6] = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b1, 1'b1}; // x tracks din[2]
      vt[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0}; // idle, ptr=3
      vt[8] = '{4'b0011, 4'b0011, 4'b0001, 1'b1, 1'b1, 1'b1}; // scan 3,0 -> 0

      @(negedge clk);
      do_reset();
      for (int i = 0; i < 9; i++) begin
         req = vt[i].req;
         din = vt[i].din;
         step();
         chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
         chk($sformatf("tbl%0d_x", i), 32'(x), 32'(vt[i].x));
         chk($sformatf("tbl%0d_vld", i), 32'(x_valid), 32'(vt[i].vld));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vt[i].busy));
      end

      // Full contention: each requester owns for exactly MH cycles, in order.
      do_reset();
      req = 4'b1111;
      din = 4'b0101;
      for (int c = 1; c <= 40; c++) begin
         step();
         chk($sformatf("full_c%0d_gnt", c), 32'(gnt), 32'(4'b0001 << (((c - 1) / MH) % N)));
         chk("full_vld", 32'(x_valid), 32'h1);
      end

      // Lone hog keeps the buffer while nobody else asks; yields at once when someone does.
      do_reset();
      req = 4'b0100;
      din = 4'b0100;
      for (int c = 1; c <= 20; c++) begin
         step();
         chk($sformatf("hog_c%0d_gnt", c), 32'(gnt), 32'h4);
      end
      req = 4'b0101;
      step();
      chk("hog_yield_gnt", 32'(gnt), 32'h1);

      // Asynchronous reset mid-grant clears outputs before any clock edge.
      din   = 4'b1111;
      rst_n = 1'b0;
      #1;
      chk("arst_gnt", 32'(gnt), 32'h0);
      chk("arst_x", 32'(x), 32'h0);
      chk("arst_vld", 32'(x_valid), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      @(negedge clk);

      // Random traffic; requests persist for stretches so hold expiry is exercised.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         din = 4'($urandom_range(0, 15));
         step();
         check_model("rnd");
         din = 4'($urandom_range(0, 15));
         #1;
         chk("rnd_xcomb", 32'(x), 32'((m_own >= 0) ? din[m_own] : 1'b0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
